seg_capture: RTL and testbench
==============================

# seg_capture

Seven-segment scan decoder for the stopwatch display path. It samples the multiplexed, active-low anode/cathode bus driven onto the board's 4-digit display. From those samples it rebuilds the four BCD digits and the minutes/seconds values. It also reports which digits were blanked (blink) and flags malformed patterns. It sits on the display pins as a self-check monitor and as a verification back-end for the display driver.

## Interface
- No parameters.
- fast_clk  in  1  scan clock, same clock that drives the display multiplexer.
- rst_n  in  1  synchronous, active-low reset, sampled on rising fast_clk.
- anode_vec  in  4  digit enables, active low, {AN3 AN2 AN1 AN0}. AN3 = minutes tens, AN0 = seconds ones.
- cathode_vec  in  7  segments, active low, {CA CB CC CD CE CF CG}.
- min  out  6  last published minutes, 0..59.
- sec  out  6  last published seconds, 0..59.
- digit_bcd  out  16  raw captured digits {d3,d2,d1,d0}, 4 bits each.
- blank_mask  out  4  bit i = digit i not lit at any point in the last published frame.
- frame_valid  out  1  one-cycle pulse when min/sec/blank_mask are published.
- frame_err  out  1  high for the frame_valid cycle if the frame contained any error; min/sec hold in that case.
- bus_err  out  1  sticky. Set on multi-anode or unknown segment pattern; cleared only by reset.

## Operation
- **Stage 0, input register:** anode_vec and cathode_vec are registered together every cycle. All decoding uses the registered copies.
- **Anode decode:**
  - Exactly one zero gives slot index 0..3.
  - All ones means an idle/blanked slot, with no observation.
  - Two or more zeros is an error: set bus_err, mark the frame bad, no observation.
- **Cathode decode** (only on a valid slot):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9.
  - 1111111 means lit-but-blank, treated as blanked for that slot.
  - Any other pattern: set bus_err, mark the frame bad, d[i] gets 4'hF.
- **Observation of slot i:**
  - Set seen[i].
  - For a decoded digit, set lit[i] and write d[i].
  - A blanked slot keeps its previous d[i].
- **Frame boundary** (either condition):
  - (a) A valid slot i is observed while seen[i] is already set.
  - (b) The idle counter reaches 8, where the idle counter counts consecutive all-ones anode cycles and saturates.
- **At the boundary:**
  - Publish blank_mask = ~lit, computed over the closing frame.
  - min = 10*d3 + d2 and sec = 10*d1 + d0, computed in 7-bit intermediates and truncated to 6 bits only after the range check.
  - If the frame is bad, or any used digit is > 9, or min > 59, or sec > 59: assert frame_err and do not update min/sec. digit_bcd still updates.
  - Pulse frame_valid.
- **Boundary (a):** the triggering observation belongs to the new frame. After the boundary, seen = lit = one-hot(i) (lit only if decoded), the bad flag is cleared, and d[i] is written.
- **Boundary (b):** seen, lit and the bad flag clear. The idle counter holds at 8 and fires no further boundaries until a valid slot is observed.

## Timing
- **Reset values:**
  - min = 0, sec = 0, digit_bcd = 0, blank_mask = 4'b1111.
  - frame_valid = 0, frame_err = 0, bus_err = 0.
  - Internal state: seen = 0, lit = 0, idle counter = 0, bad flag = 0.
- **Latency:** pin values present before edge k are registered at edge k and evaluated at edge k+1. Outputs and frame_valid are therefore visible after edge k+1, i.e. 2 cycles from pins to frame_valid.
- **frame_valid:** exactly 1 cycle wide. With a 4-slot scan it recurs every 4 cycles.
- **Reset mid-frame:** the partial frame is discarded and no frame_valid is produced. The first boundary after reset needs a repeated slot, as usual.
- **Simultaneous error and boundary on the same sample:** the error is charged to the new frame. bus_err still sets.
- **Slot order:** arbitrary. Only repetition closes a frame, so non-sequential or reversed scans are accepted.

## Test plan
- **Digits 1,2,3,4:** scan AN0..AN3 repeatedly with patterns for 4,3,2,1 → from the second pass onward, frame_valid every 4 cycles, min=12, sec=34, blank_mask=0000, frame_err=0.
- **Minutes blinking:** hold AN3/AN2 high (blanked) for 8 frames with d3,d2 previously 0,5 and seconds 59 → min=5, sec=59, blank_mask=1100, frame_err=0.
- **Bad segment:** present 1111110 on AN1 → bus_err=1 from then on. That frame has frame_err=1 and min/sec unchanged. The next clean frame has frame_err=0.
- **Two anodes low:** anode_vec=0011 for one cycle → bus_err=1, frame_err on that frame.
- **Full blank:** anode_vec=1111 for 8 cycles → exactly one frame_valid with blank_mask=1111, then none until the scan resumes.
- **Reset mid-frame:** pull rst_n low for one edge after AN0 and AN1 have been scanned → all outputs at reset values. The first frame_valid appears only after a slot repeats, with correct values.

Source files
------------

// File: rtl/seg_capture.sv
// Seven-segment scan monitor: rebuilds the four BCD digits and min/sec values
// from the multiplexed active-low anode/cathode display bus.
module seg_capture (
    input  logic        fast_clk,
    input  logic        rst_n,
    input  logic [3:0]  anode_vec,
    input  logic [6:0]  cathode_vec,
    output logic [5:0]  min,
    output logic [5:0]  sec,
    output logic [15:0] digit_bcd,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        bus_err
);

    logic [3:0]      an_q;
    logic [6:0]      ca_q;
    logic [3:0]      seen, lit;
    logic [3:0][3:0] d;
    logic [3:0]      idle_cnt;
    logic            bad;

    logic       idle, one_hot, multi, known, blank, dec, unk, bnd_a, bnd_b, range_err;
    logic [1:0] slot;
    logic [3:0] slot_oh, val;
    logic [6:0] min_w, sec_w;

    always_comb begin
        one_hot = 1'b1;
        slot    = 2'd0;
        case (an_q)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: one_hot = 1'b0;
        endcase
        idle    = (an_q == 4'hF);
        multi   = !idle && !one_hot;
        slot_oh = ~an_q;

        known = 1'b1;
        val   = 4'd0;
        case (ca_q)
            7'b0000001: val = 4'd0;
            7'b1001111: val = 4'd1;
            7'b0010010: val = 4'd2;
            7'b0000110: val = 4'd3;
            7'b1001100: val = 4'd4;
            7'b0100100: val = 4'd5;
            7'b0100000: val = 4'd6;
            7'b0001111: val = 4'd7;
            7'b0000000: val = 4'd8;
            7'b0001100: val = 4'd9;
            default:    known = 1'b0;
        endcase
        blank = (ca_q == 7'h7F);
        dec   = one_hot && known;
        unk   = one_hot && !known && !blank;

        // A repeated slot closes the frame; the triggering sample opens the next one.
        bnd_a = one_hot && ((seen & slot_oh) != 4'd0);
        bnd_b = idle && (idle_cnt == 4'd7);

        min_w     = {3'b000, d[3]} * 7'd10 + {3'b000, d[2]};
        sec_w     = {3'b000, d[1]} * 7'd10 + {3'b000, d[0]};
        range_err = bad || (d[3] > 4'd9) || (d[2] > 4'd9) || (d[1] > 4'd9) ||
                    (d[0] > 4'd9) || (min_w > 7'd59) || (sec_w > 7'd59);
    end

    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            an_q        <= 4'hF;
            ca_q        <= 7'h7F;
            seen        <= 4'd0;
            lit         <= 4'd0;
            d           <= '0;
            idle_cnt    <= 4'd0;
            bad         <= 1'b0;
            min         <= 6'd0;
            sec         <= 6'd0;
            digit_bcd   <= 16'd0;
            blank_mask  <= 4'hF;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            an_q        <= anode_vec;
            ca_q        <= cathode_vec;
            frame_valid <= bnd_a || bnd_b;
            frame_err   <= 1'b0;
            if (unk || multi)
                bus_err <= 1'b1;

            if (!idle)
                idle_cnt <= 4'd0;
            else if (idle_cnt != 4'd8)
                idle_cnt <= idle_cnt + 4'd1;

            if (bnd_a || bnd_b) begin
                blank_mask <= ~lit;
                digit_bcd  <= d;
                frame_err  <= range_err;
                if (!range_err) begin
                    min <= min_w[5:0];
                    sec <= sec_w[5:0];
                end
            end

            if (bnd_a) begin
                seen <= slot_oh;
                lit  <= dec ? slot_oh : 4'd0;
                bad  <= unk;
            end else if (bnd_b) begin
                seen <= 4'd0;
                lit  <= 4'd0;
                bad  <= 1'b0;
            end else begin
                if (one_hot)
                    seen <= seen | slot_oh;
                if (dec)
                    lit <= lit | slot_oh;
                if (unk || multi)
                    bad <= 1'b1;
            end

            if (dec)
                d[slot] <= val;
            else if (unk)
                d[slot] <= 4'hF;
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed display scans plus random bus traffic,
// compared every cycle against a frame-level behavioural model.
module tb_seg_capture;

    logic        fast_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  anode_vec = 4'hF;
    logic [6:0]  cathode_vec = 7'h7F;
    logic [5:0]  min, sec;
    logic [15:0] digit_bcd;
    logic [3:0]  blank_mask;
    logic        frame_valid, frame_err, bus_err;

    seg_capture dut (
        .fast_clk(fast_clk), .rst_n(rst_n), .anode_vec(anode_vec), .cathode_vec(cathode_vec),
        .min(min), .sec(sec), .digit_bcd(digit_bcd), .blank_mask(blank_mask),
        .frame_valid(frame_valid), .frame_err(frame_err), .bus_err(bus_err)
    );

    always #5 fast_clk = ~fast_clk;

    int n_vec = 0, n_err = 0;
    int fv_cnt = 0, fe_cnt = 0;
    logic [3:0] last_blank = 4'hF;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

    // model state: what has been seen of the frame currently being collected
    logic [3:0]  m_pa = 4'hF;
    logic [6:0]  m_pc = 7'h7F;
    bit          m_seen [4];
    bit          m_lit  [4];
    int          m_d    [4];
    int          m_idle = 0;
    bit          m_bad  = 0;
    logic [5:0]  exp_min = 0, exp_sec = 0;
    logic [15:0] exp_dig = 0;
    logic [3:0]  exp_blank = 4'hF;
    logic        exp_fv = 0, exp_fe = 0, exp_bus = 0;

    // 0..9 digit, 10 blank, 11 unknown
    function automatic int decode_seg(input logic [6:0] c);
        if (c == 7'h7F) return 10;
        for (int v = 0; v < 10; v++)
            if (seg_tab[v] == c) return v;
        return 11;
    endfunction

    function automatic logic [3:0] an_of(input int i);
        logic [3:0] a;
        a = 4'b0001 << i;
        return ~a;
    endfunction

    task automatic new_frame();
        for (int i = 0; i < 4; i++) begin
            m_seen[i] = 0;
            m_lit[i]  = 0;
        end
        m_bad = 0;
    endtask

    task automatic close_frame();
        int  m, s;
        bit  err;
        exp_fv = 1;
        err = m_bad;
        for (int i = 0; i < 4; i++) begin
            exp_blank[i]      = !m_lit[i];
            exp_dig[4*i +: 4] = m_d[i][3:0];
            if (m_d[i] > 9) err = 1;
        end
        m = 10 * m_d[3] + m_d[2];
        s = 10 * m_d[1] + m_d[0];
        if (m > 59 || s > 59) err = 1;
        exp_fe = err;
        if (!err) begin
            exp_min = m[5:0];
            exp_sec = s[5:0];
        end
    endtask

    task automatic model_reset();
        new_frame();
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_idle = 0;
        m_pa = 4'hF; m_pc = 7'h7F;
        exp_min = 0; exp_sec = 0; exp_dig = 0; exp_blank = 4'hF;
        exp_fv = 0; exp_fe = 0; exp_bus = 0;
    endtask

    task automatic model_eval();
        int z, i, k;
        exp_fv = 0;
        exp_fe = 0;
        z = 0;
        i = 0;
        for (int b = 0; b < 4; b++)
            if (!m_pa[b]) begin z++; i = b; end
        if (z == 0) begin
            if (m_idle < 8) begin
                m_idle++;
                if (m_idle == 8) begin close_frame(); new_frame(); end
            end
        end else if (z > 1) begin
            m_idle = 0; m_bad = 1; exp_bus = 1;
        end else begin
            m_idle = 0;
            k = decode_seg(m_pc);
            if (m_seen[i]) begin close_frame(); new_frame(); end
            m_seen[i] = 1;
            if (k < 10) begin
                m_lit[i] = 1; m_d[i] = k;
            end else if (k == 11) begin
                m_d[i] = 15; m_bad = 1; exp_bus = 1;
            end
        end
    endtask

    initial model_reset();

    always @(posedge fast_clk) begin
        if (!rst_n) model_reset();
        else begin
            model_eval();
            m_pa = anode_vec;
            m_pc = cathode_vec;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge fast_clk) begin
        chk("min", min, exp_min);
        chk("sec", sec, exp_sec);
        chk("digit_bcd", digit_bcd, exp_dig);
        chk("blank_mask", blank_mask, exp_blank);
        chk("frame_valid", frame_valid, exp_fv);
        chk("frame_err", frame_err, exp_fe);
        chk("bus_err", bus_err, exp_bus);
        if (frame_valid) begin
            fv_cnt++;
            last_blank = blank_mask;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic put(input logic [3:0] a, input logic [6:0] c);
        anode_vec   = a;
        cathode_vec = c;
        @(posedge fast_clk);
        #1;
    endtask

    task automatic look();
        @(negedge fast_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        put(4'hF, 7'h7F);
        rst_n = 1'b1;
    endtask

    task automatic scan(input int v3, input int v2, input int v1, input int v0);
        put(an_of(0), seg_tab[v0]);
        put(an_of(1), seg_tab[v1]);
        put(an_of(2), seg_tab[v2]);
        put(an_of(3), seg_tab[v3]);
    endtask

    initial begin
        int b_fv, b_fe, r, n;
        logic [3:0] a;
        logic [6:0] c;

        // reset state
        rst_n = 1'b0;
        put(4'hF, 7'h7F);
        put(4'hF, 7'h7F);
        look();
        chk("rst_min", min, 0);
        chk("rst_sec", sec, 0);
        chk("rst_digits", digit_bcd, 0);
        chk("rst_blank", blank_mask, 4'hF);
        chk("rst_fv", frame_valid, 0);
        chk("rst_bus", bus_err, 0);
        rst_n = 1'b1;

        // digits 1,2,3,4
        b_fv = fv_cnt; b_fe = fe_cnt;
        repeat (3) scan(1, 2, 3, 4);
        put(an_of(0), seg_tab[4]);
        look();
        chk("t1_fv_count", fv_cnt - b_fv, 2);
        chk("t1_fe_count", fe_cnt - b_fe, 0);
        chk("t1_min", min, 12);
        chk("t1_sec", sec, 34);
        chk("t1_digits", digit_bcd, 16'h1234);
        chk("t1_blank", blank_mask, 0);
        chk("t1_model_min", exp_min, 12);

        // minutes blinking
        repeat (2) scan(0, 5, 5, 9);
        b_fe = fe_cnt;
        repeat (16) begin
            put(an_of(0), seg_tab[9]);
            put(an_of(1), seg_tab[5]);
        end
        look();
        chk("t2_min", min, 5);
        chk("t2_sec", sec, 59);
        chk("t2_blank", blank_mask, 4'b1100);
        chk("t2_fe_count", fe_cnt - b_fe, 0);
        chk("t2_model_blank", exp_blank, 4'b1100);

        // bad segment on AN1
        b_fv = fv_cnt; b_fe = fe_cnt;
        put(an_of(0), seg_tab[9]);
        put(an_of(1), 7'b1111110);
        repeat (3) begin
            put(an_of(0), seg_tab[9]);
            put(an_of(1), seg_tab[5]);
        end
        look();
        chk("t3_bus", bus_err, 1);
        chk("t3_fe_count", fe_cnt - b_fe, 1);
        chk("t3_fv_count", fv_cnt - b_fv, 4);
        chk("t3_min", min, 5);
        chk("t3_sec", sec, 59);

        // two anodes low
        do_reset();
        look();
        chk("t4_bus_after_rst", bus_err, 0);
        b_fe = fe_cnt;
        scan(1, 2, 3, 4);
        put(an_of(0), seg_tab[4]);
        put(4'b0011, seg_tab[3]);
        put(an_of(1), seg_tab[3]);
        put(an_of(2), seg_tab[2]);
        put(an_of(3), seg_tab[1]);
        put(an_of(0), seg_tab[4]);
        put(an_of(1), seg_tab[3]);
        put(an_of(2), seg_tab[2]);
        put(an_of(3), seg_tab[1]);
        put(an_of(0), seg_tab[4]);
        put(an_of(1), seg_tab[3]);
        look();
        chk("t4_bus", bus_err, 1);
        chk("t4_fe_count", fe_cnt - b_fe, 1);
        chk("t4_min", min, 12);
        chk("t4_sec", sec, 34);

        // full blank
        do_reset();
        b_fv = fv_cnt; b_fe = fe_cnt;
        repeat (12) put(4'hF, 7'h7F);
        look();
        chk("t5_fv_count", fv_cnt - b_fv, 1);
        chk("t5_fe_count", fe_cnt - b_fe, 0);
        chk("t5_blank", last_blank, 4'hF);

        // reset mid-frame
        repeat (2) scan(1, 2, 3, 4);
        put(an_of(0), seg_tab[4]);
        put(an_of(1), seg_tab[3]);
        rst_n = 1'b0;
        put(an_of(2), seg_tab[2]);
        rst_n = 1'b1;
        look();
        chk("t6_rst_min", min, 0);
        chk("t6_rst_digits", digit_bcd, 0);
        chk("t6_rst_blank", blank_mask, 4'hF);
        b_fv = fv_cnt;
        put(an_of(3), seg_tab[1]);
        put(an_of(0), seg_tab[4]);
        put(an_of(1), seg_tab[3]);
        put(an_of(2), seg_tab[2]);
        look();
        chk("t6_no_fv", fv_cnt - b_fv, 0);
        put(an_of(3), seg_tab[1]);
        put(an_of(0), seg_tab[4]);
        look();
        chk("t6_fv_count", fv_cnt - b_fv, 1);
        chk("t6_min", min, 12);
        chk("t6_sec", sec, 34);
        chk("t6_blank", blank_mask, 0);

        // random traffic
        for (int it = 0; it < 2500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                put(an_of($urandom_range(0, 3)), seg_tab[$urandom_range(0, 9)]);
            end else if (r < 78) begin
                put(an_of($urandom_range(0, 3)), 7'h7F);
            end else if (r < 80) begin
                do c = 7'($urandom_range(0, 127)); while (decode_seg(c) != 11);
                put(an_of($urandom_range(0, 3)), c);
            end else if (r < 82) begin
                do a = 4'($urandom_range(0, 14)); while ($countones(a) > 2);
                put(a, seg_tab[$urandom_range(0, 9)]);
            end else if (r < 97) begin
                n = $urandom_range(1, 12);
                repeat (n) put(4'hF, 7'($urandom_range(0, 127)));
            end else begin
                do_reset();
            end
        end
        look();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
